// File: rtl/fpgalink_chan_bridge.sv
// Channel bridge behind the FX2 comm block: one channel feeds an RX/TX byte FIFO pair,
// a window of channels maps to a register file. Optional status channel 127 via FPGALINK_BRIDGE_STATUS_EN.
module fpgalink_chan_bridge #(
    parameter int FIFO_CHAN  = 0,
    parameter int DEPTH_LOG2 = 4,
    parameter int REG_BASE   = 1,
    parameter int NREGS      = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [6:0]            chanAddr_in,
    input  logic [7:0]            h2fData_in,
    input  logic                  h2fValid_in,
    output logic                  h2fReady_out,
    output logic [7:0]            f2hData_out,
    output logic                  f2hValid_out,
    input  logic                  f2hReady_in,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [8*NREGS-1:0]    regs_out,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [7:0]            REG_LO    = 8'(REG_BASE);
    localparam logic [7:0]            REG_HI    = 8'(REG_BASE + NREGS);
    localparam logic [6:0]            FIFO_ADDR = 7'(FIFO_CHAN);

    logic [7:0] addrExt;
    logic [7:0] regIdx;
    logic       isFifo;
    logic       isReg;
    logic       isStat;

    assign addrExt = {1'b0, chanAddr_in};
    assign regIdx  = addrExt - REG_LO;
    assign isFifo  = (chanAddr_in == FIFO_ADDR);
    assign isReg   = (addrExt >= REG_LO) && (addrExt < REG_HI);

    logic rxFlush;
    logic txFlush;

`ifdef FPGALINK_BRIDGE_STATUS_EN
    assign isStat  = (chanAddr_in == 7'd127);
    assign rxFlush = isStat && h2fValid_in && h2fData_in[0];
    assign txFlush = isStat && h2fValid_in && h2fData_in[1];
`else
    assign isStat  = 1'b0;
    assign rxFlush = 1'b0;
    assign txFlush = 1'b0;
`endif

    logic [7:0]            rxMem [DEPTH];
    logic [DEPTH_LOG2-1:0] rxWr;
    logic [DEPTH_LOG2-1:0] rxRd;
    logic [DEPTH_LOG2:0]   rxCnt;
    logic                  rxFull;
    logic                  rxEmpty;
    logic                  rxPush;
    logic                  rxPop;

    logic [7:0]            txMem [DEPTH];
    logic [DEPTH_LOG2-1:0] txWr;
    logic [DEPTH_LOG2-1:0] txRd;
    logic [DEPTH_LOG2:0]   txCnt;
    logic                  txFull;
    logic                  txEmpty;
    logic                  txPush;
    logic                  txPop;
    logic [7:0]            txHead;

    assign rxFull  = (rxCnt == FULL_CNT);
    assign rxEmpty = (rxCnt == '0);
    assign txFull  = (txCnt == FULL_CNT);
    assign txEmpty = (txCnt == '0);

    // Handshakes are gated by full/empty, so illegal pushes and pops never reach the FIFOs.
    assign rxPush = isFifo && h2fValid_in && !rxFull;
    assign rxPop  = !rxEmpty && rx_ready;
    assign txPush = tx_valid && !txFull;
    assign txPop  = isFifo && !txEmpty && f2hReady_in;

    assign rx_data  = rxMem[rxRd];
    assign rx_valid = !rxEmpty;
    assign rx_count = rxCnt;
    assign txHead   = txMem[txRd];
    assign tx_ready = !txFull;
    assign tx_count = txCnt;

    always_ff @(posedge clk_in) begin
        if (rxPush) rxMem[rxWr] <= h2fData_in;
        if (txPush) txMem[txWr] <= tx_data;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rxWr  <= '0;
            rxRd  <= '0;
            rxCnt <= '0;
        end else if (rxFlush) begin
            rxWr  <= '0;
            rxRd  <= '0;
            rxCnt <= '0;
        end else begin
            if (rxPush) rxWr <= rxWr + PTR_ONE;
            if (rxPop)  rxRd <= rxRd + PTR_ONE;
            case ({rxPush, rxPop})
                2'b10:   rxCnt <= rxCnt + CNT_ONE;
                2'b01:   rxCnt <= rxCnt - CNT_ONE;
                default: rxCnt <= rxCnt;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            txWr  <= '0;
            txRd  <= '0;
            txCnt <= '0;
        end else if (txFlush) begin
            txWr  <= '0;
            txRd  <= '0;
            txCnt <= '0;
        end else begin
            if (txPush) txWr <= txWr + PTR_ONE;
            if (txPop)  txRd <= txRd + PTR_ONE;
            case ({txPush, txPop})
                2'b10:   txCnt <= txCnt + CNT_ONE;
                2'b01:   txCnt <= txCnt - CNT_ONE;
                default: txCnt <= txCnt;
            endcase
        end
    end

    logic [8*NREGS-1:0] regsQ;
    logic [7:0]         regRead;
    logic [7:0]         statusByte;

    // Register file is cleared on reset so the application sees a known configuration.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            regsQ <= '0;
        end else if (isReg && h2fValid_in) begin
            for (int k = 0; k < NREGS; k++)
                if (regIdx == 8'(k)) regsQ[8*k +: 8] <= h2fData_in;
        end
    end

    always_comb begin
        regRead = 8'h00;
        for (int k = 0; k < NREGS; k++)
            if (regIdx == 8'(k)) regRead = regsQ[8*k +: 8];
    end

    assign regs_out   = regsQ;
    assign statusByte = {rxFull, rxEmpty, txFull, txEmpty, 4'b0000};

    always_comb begin
        h2fReady_out = 1'b1;
        if (isFifo) h2fReady_out = !rxFull;
    end

    always_comb begin
        f2hValid_out = 1'b1;
        f2hData_out  = 8'h00;
        if (isFifo) begin
            f2hValid_out = !txEmpty;
            f2hData_out  = txHead;
        end else if (isReg) begin
            f2hData_out  = regRead;
        end else if (isStat) begin
            f2hData_out  = statusByte;
        end
    end
endmodule

// File: tb/tb_fpgalink_chan_bridge.sv
// Directed bench for fpgalink_chan_bridge: queue-based reference model checked every cycle,
// plus literal expectations at key points.
module tb_fpgalink_chan_bridge;
    localparam int NREGS = 8;
    localparam int DEPTH = 16;
`ifdef FPGALINK_BRIDGE_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  chanAddr;
    logic [7:0]  h2fData;
    logic        h2fValid;
    logic        h2fReady;
    logic [7:0]  f2hData;
    logic        f2hValid;
    logic        f2hReady;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [63:0] regsOut;
    logic [4:0]  rxCount;
    logic [4:0]  txCount;

    fpgalink_chan_bridge dut (
        .clk_in(clk), .reset_in(rst), .chanAddr_in(chanAddr),
        .h2fData_in(h2fData), .h2fValid_in(h2fValid), .h2fReady_out(h2fReady),
        .f2hData_out(f2hData), .f2hValid_out(f2hValid), .f2hReady_in(f2hReady),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .regs_out(regsOut), .rx_count(rxCount), .tx_count(txCount)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    byte unsigned rxq[$];
    byte unsigned txq[$];
    logic [7:0] regsM [NREGS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare outputs, then advance model state to what the next edge produces.
    initial forever begin
        bit isF, isR, isS, rxPush, rxPop, txPush, txPop, rxFl, txFl;
        logic [63:0] expRegs;
        logic [7:0]  expF2h;
        @(negedge clk);
        if (rst) begin
            rxq.delete();
            txq.delete();
            foreach (regsM[k]) regsM[k] = 8'h00;
        end
        isF = (chanAddr == 7'd0);
        isR = (chanAddr >= 7'd1) && (chanAddr <= 7'd8);
        isS = STAT && (chanAddr == 7'd127);
        expRegs = '0;
        foreach (regsM[k]) expRegs[8*k +: 8] = regsM[k];
        chk("regs_out", regsOut, expRegs);
        chk("rx_count", rxCount, 64'(rxq.size()));
        chk("tx_count", txCount, 64'(txq.size()));
        chk("rx_valid", rxValid, 64'(rxq.size() > 0));
        chk("tx_ready", txReady, 64'(txq.size() < DEPTH));
        if (rxq.size() > 0) chk("rx_data", rxData, 64'(rxq[0]));
        chk("h2fReady", h2fReady, isF ? 64'(rxq.size() < DEPTH) : 64'd1);
        chk("f2hValid", f2hValid, isF ? 64'(txq.size() > 0) : 64'd1);
        if (isF) expF2h = (txq.size() > 0) ? txq[0] : 8'h00;
        else if (isR) expF2h = regsM[chanAddr - 7'd1];
        else if (isS) expF2h = {rxq.size() == DEPTH, rxq.size() == 0,
                                txq.size() == DEPTH, txq.size() == 0, 4'b0000};
        else expF2h = 8'h00;
        if (!isF || txq.size() > 0) chk("f2hData", f2hData, 64'(expF2h));
        if (!rst) begin
            rxPush = isF && h2fValid && (rxq.size() < DEPTH);
            rxPop  = (rxq.size() > 0) && rxReady;
            txPush = txValid && (txq.size() < DEPTH);
            txPop  = isF && (txq.size() > 0) && f2hReady;
            rxFl   = isS && h2fValid && h2fData[0];
            txFl   = isS && h2fValid && h2fData[1];
            if (rxFl) rxq.delete();
            else begin
                if (rxPop)  void'(rxq.pop_front());
                if (rxPush) rxq.push_back(h2fData);
            end
            if (txFl) txq.delete();
            else begin
                if (txPop)  void'(txq.pop_front());
                if (txPush) txq.push_back(txData);
            end
            if (isR && h2fValid) regsM[chanAddr - 7'd1] = h2fData;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vecs);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; chanAddr = 7'd0; h2fData = 8'h00; h2fValid = 1'b0; f2hReady = 1'b0;
        rxReady = 1'b0; txData = 8'h00; txValid = 1'b0;
        #2;
        chk("reset h2fReady", h2fReady, 1);
        chk("reset f2hValid", f2hValid, 0);
        chk("reset rx_valid", rxValid, 0);
        chk("reset tx_ready", txReady, 1);
        chk("reset regs", regsOut, 0);
        chk("reset rx_count", rxCount, 0);
        chk("reset tx_count", txCount, 0);
        cyc(); cyc();
        rst = 1'b0;

        // Fill RX to full.
        h2fValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            h2fData = 8'(8'h10 + i);
            cyc();
        end
        // Push and pop together at full: first push is blocked, second is accepted.
        h2fData = 8'h20; rxReady = 1'b1;
        #1;
        chk("full rx_count", rxCount, 16);
        chk("full h2fReady", h2fReady, 0);
        chk("full head", rxData, 8'h10);
        cyc();
        #1;
        chk("after pop h2fReady", h2fReady, 1);
        chk("after pop head", rxData, 8'h11);
        chk("after pop rx_count", rxCount, 15);
        cyc();
        h2fValid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("drain order", rxData, (i < 14) ? 64'(8'h12 + i) : 64'h20);
            cyc();
        end
        #1;
        chk("drained rx_valid", rxValid, 0);
        chk("drained rx_count", rxCount, 0);
        rxReady = 1'b0;

        // TX path to host.
        txValid = 1'b1; txData = 8'hA5;
        cyc();
        txData = 8'h5A;
        cyc();
        txValid = 1'b0;
        #1;
        chk("tx loaded count", txCount, 2);
        f2hReady = 1'b1;
        #1;
        chk("tx first valid", f2hValid, 1);
        chk("tx first byte", f2hData, 8'hA5);
        cyc();
        #1;
        chk("tx second byte", f2hData, 8'h5A);
        cyc();
        #1;
        chk("tx empty valid", f2hValid, 0);
        chk("tx empty count", txCount, 0);

        // Register window, with a TX push while the FIFO channel is not selected.
        chanAddr = 7'd3; h2fData = 8'h3C; h2fValid = 1'b1;
        txValid = 1'b1; txData = 8'hB7;
        cyc();
        h2fValid = 1'b0; txValid = 1'b0;
        #1;
        chk("reg3 regs_out", regsOut[23:16], 8'h3C);
        chk("reg3 read", f2hData, 8'h3C);
        chk("reg3 valid", f2hValid, 1);
        chk("tx held off-channel", txCount, 1);
        chanAddr = 7'd50;
        #1;
        chk("chan50 valid", f2hValid, 1);
        chk("chan50 data", f2hData, 8'h00);
        h2fData = 8'hFF; h2fValid = 1'b1;
        cyc();
        h2fValid = 1'b0;
        #1;
        chk("chan50 write ignored", regsOut, 64'h0000_0000_003C_0000);
        h2fValid = 1'b1;
        chanAddr = 7'd8; h2fData = 8'h77; cyc();
        chanAddr = 7'd9; h2fData = 8'h99; cyc();
        chanAddr = 7'd1; h2fData = 8'h11; cyc();
        h2fValid = 1'b0;
        #1;
        chk("window edges", regsOut, 64'h7700_0000_003C_0011);
        chanAddr = 7'd8;
        #1;
        chk("reg8 read", f2hData, 8'h77);

        // Reset mid-transfer discards buffered bytes and registers.
        chanAddr = 7'd0; h2fValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h2fData = 8'(8'h61 + i);
            cyc();
        end
        h2fValid = 1'b0;
        #1;
        chk("pre-reset rx_count", rxCount, 3);
        rst = 1'b1;
        #1;
        chk("mid reset rx_count", rxCount, 0);
        chk("mid reset tx_count", txCount, 0);
        chk("mid reset regs", regsOut, 0);
        cyc();
        rst = 1'b0;

        // Status channel (decoded only when the feature is built in).
        h2fValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h2fData = 8'(8'hC1 + i);
            cyc();
        end
        chanAddr = 7'd127; h2fData = 8'h01;
        cyc();
        h2fValid = 1'b0;
        #1;
`ifdef FPGALINK_BRIDGE_STATUS_EN
        chk("rx flushed", rxCount, 0);
        chk("status read", f2hData, 8'h50);
        chk("status valid", f2hValid, 1);
        txValid = 1'b1; txData = 8'hE1;
        cyc();
        h2fValid = 1'b1; h2fData = 8'h02;
        cyc();
        h2fValid = 1'b0; txValid = 1'b0;
        #1;
        chk("tx flush beats push", txCount, 0);
`else
        chk("chan127 no flush", rxCount, 3);
        chk("chan127 read", f2hData, 8'h00);
        chk("chan127 valid", f2hValid, 1);
`endif
        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
